// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS core.
// Ports: clk, reset (sync, active-high), opcode/zero/mem_ready in;
//   datapath selects, write strobes, instr_done, illegal_op and state out.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ext_zero,
  output logic [2:0] ALUop,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_FN  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t     cur;
  state_t     nxt;
  logic [5:0] op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= S_FETCH;
      op_q <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE)
        op_q <= opcode;
    end
  end

  assign state = cur;

  always_comb begin
    nxt        = S_FETCH;
    mem_req    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ext_zero   = 1'b0;
    ALUop      = ALU_ADD;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    unique case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        nxt     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculative branch target lands in ALUOut.
        ALUSrcB = 2'b11;
        unique case (opcode)
          OP_LW, OP_SW:            nxt = S_MEMADR;
          OP_R:                    nxt = S_EXEC;
          OP_BEQ, OP_BNE:          nxt = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: nxt = S_IEXEC;
          OP_J:                    nxt = S_JUMP;
          default: begin
            nxt        = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        nxt     = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        // Strobe held for every stalled cycle until memory accepts.
        mem_req    = 1'b1;
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
        nxt        = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = ALU_FN;
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUop      = ALU_SUB;
        PCSrc      = 2'b01;
        PCWrite    = ((op_q == OP_BEQ) & zero) |
                     ((op_q == OP_BNE) & ~zero);
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        unique case (1'b1)
          op_q == OP_ANDI: begin
            ALUop    = ALU_AND;
            ext_zero = 1'b1;
          end
          op_q == OP_ORI: begin
            ALUop    = ALU_OR;
            ext_zero = 1'b1;
          end
          default: ALUop = ALU_ADD;
        endcase
        nxt = S_IWB;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase

    // Reset aborts whatever was in flight: show fetch selects, no strobes.
    if (reset) begin
      nxt        = S_FETCH;
      mem_req    = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b01;
      ext_zero   = 1'b0;
      ALUop      = ALU_ADD;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control FSM for the multicycle MIPS core; sequences the shared datapath (single ALU, unified instruction/data memory, register file) through fetch, decode, execute, memory and writeback steps. Generates the 3-bit ALU operation class consumed by the ALU control decoder, the datapath mux selects and all write strobes. Stalls on a memory ready handshake in memory-access states.

## Interface
Parameters:
- none (opcode encodings are fixed constants)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- PCWrite  out  1  PC load (unconditional or branch-qualified)
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign/zero-ext imm, 11 ext imm << 2
- ext_zero  out  1  1 = zero-extend immediate (andi/ori)
- ALUop  out  3  000 add, 001 sub, 010 use funct, 011 and, 100 or
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = memory data register
- RegWrite  out  1  register file write strobe
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state (debug)

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010.
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11. Codes 12-15 unreachable; if entered, next state FETCH.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=000, PCSrc=00; IRWrite=PCWrite=mem_ready; stay until mem_ready=1, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=000 (branch target into ALUOut); opcode latched into op_q. Next: lw/sw->MEMADR, R-type->EXEC, beq/bne->BRANCH, addi/andi/ori->IEXEC, j->JUMP, other->FETCH with illegal_op=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=000. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, IorD=1; hold until mem_ready, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1 -> FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=1; hold until mem_ready; on mem_ready instr_done=1 -> FETCH. MemWrite stays high for every stalled cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=010 -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=001, PCSrc=01; PCWrite = (op_q==beq & zero) | (op_q==bne & ~zero); instr_done=1 -> FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10; ALUop 000 addi, 011 andi, 100 ori; ext_zero=1 for andi/ori -> IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1, instr_done=1 -> FETCH.
- All outputs not listed for a state are 0. Outputs are combinational decodes of state (plus mem_ready, zero, op_q as listed).

## Timing
- Reset: state <= FETCH, op_q <= 0 at the first rising edge with reset=1. While reset=1, mem_req, MemWrite, IRWrite, PCWrite, RegWrite, instr_done, illegal_op forced 0; other outputs show FETCH values (IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=000, PCSrc=00, rest 0).
- Reset mid-instruction (including a stalled MEMWR): aborts; no strobe asserted in the reset cycle; next instruction begins at FETCH.
- Cycle counts with mem_ready=1: j 3, beq/bne 3, R-type 4, addi/andi/ori 4, sw 4, lw 5; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
- mem_ready is ignored in non-memory states.
- zero is sampled only in BRANCH, same cycle as PCWrite.

## Test plan
- Reset, then R-type add with mem_ready=1 -> states 0,1,6,7,0; ALUop=010 in EXEC; RegWrite=1,RegDst=1 only in ALUWB; instr_done one pulse.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMRD -> 10 cycles total; IRWrite/PCWrite single pulse on fetch ready; MemtoReg=1,RegWrite=1 in MEMWB.
- beq zero=1 then bne zero=1 -> PCWrite=1 with PCSrc=01 for beq; PCWrite=0 for bne; both 3 cycles.
- andi then ori -> IEXEC ALUop=011 then 100, ext_zero=1; addi -> ALUop=000, ext_zero=0.
- Opcode 111111 -> DECODE asserts illegal_op one cycle, returns to FETCH, no RegWrite/MemWrite.
- sw with mem_ready=0, assert reset in MEMWR -> MemWrite=0 during reset cycle, state=0 afterwards, then j executes in 3 cycles with PCSrc=10.
